// File: rtl/seq_bitgen_pkg.sv
// seq_bitgen_pkg: shared types, default constants and a width helper for the
// seq_bitgen parallel-to-serial stage.
package seq_bitgen_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int unsigned SEQ_WIDTH    = 8;
  localparam int unsigned SEQ_DIV      = 1;
  localparam logic        SEQ_IDLE_LVL = 1'b0;

  // Divider counter width; a DIV of 1 still keeps a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage : seq_bitgen_pkg

// File: rtl/seq_bitgen_tick.sv
// seq_bitgen_tick: bit-period divider. Counts 0..DIV-1 while enabled and
// flags the last cycle of each bit period.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   en   - count enable (block is shifting)
//   clr  - restart the bit period (word load)
//   tick - high in the last cycle of a bit period
module seq_bitgen_tick
  import seq_bitgen_pkg::*;
#(
  parameter int unsigned DIV = SEQ_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = en && (r_cnt == LAST);
  assign tick   = w_tick;

  // Wraps on tick; held at zero while idle or when a new word is loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || !en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule : seq_bitgen_tick

// File: rtl/seq_bitgen.sv
// seq_bitgen: accepts WIDTH-bit words over valid/ready and shifts them out
// MSB-first on x, each bit held DIV cycles. A one-word holding register lets
// consecutive words stream without a gap.
// Optional build macro: SEQ_BITGEN_REPEAT_EN - when defined, the last word
// repeats until a new word arrives instead of returning to idle.
// Ports:
//   clk, rst  - clock; synchronous active-low reset
//   din       - parallel word, qualified by din_valid
//   din_ready - holding register empty
//   x         - serial bit (IDLE_LVL when idle)
//   x_valid   - a word is being shifted
//   bit_stb   - last cycle of each bit period
//   word_done - bit_stb of bit 0 of a word
//   bit_idx   - index of the bit currently on x
module seq_bitgen
  import seq_bitgen_pkg::*;
#(
  parameter int unsigned WIDTH    = SEQ_WIDTH,
  parameter int unsigned DIV      = SEQ_DIV,
  parameter logic        IDLE_LVL = SEQ_IDLE_LVL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     x,
  output logic                     x_valid,
  output logic                     bit_stb,
  output logic                     word_done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned   IW      = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  state_t           r_state,     w_state_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic [WIDTH-1:0] r_hold,      w_hold_nxt;
  logic [WIDTH-1:0] r_shift,     w_shift_nxt;
  logic [IW-1:0]    r_idx,       w_idx_nxt;
  logic             w_load;
  logic             w_word_done;
  logic             w_tick;

`ifdef SEQ_BITGEN_REPEAT_EN
  logic [WIDTH-1:0] r_last;
`endif

  seq_bitgen_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state == S_SHIFT),
    .clr  (w_load),
    .tick (w_tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_idx       <= IDX_TOP;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_hold      <= w_hold_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

`ifdef SEQ_BITGEN_REPEAT_EN
  // Copy of the most recently loaded word, replayed when nothing is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= '0;
    end else if (w_load) begin
      r_last <= r_hold;
    end
  end
`endif

  // Next-state logic. Accept needs an empty holding register and load needs a
  // full one, so the two never coincide.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_full_nxt = r_hold_full;
    w_hold_nxt      = r_hold;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_load          = 1'b0;
    w_word_done     = 1'b0;

    if (din_valid && !r_hold_full) begin
      w_hold_nxt      = din;
      w_hold_full_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          if (r_idx != '0) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
            w_idx_nxt   = r_idx - IW'(1);
          end else begin
            w_word_done = 1'b1;
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
`ifdef SEQ_BITGEN_REPEAT_EN
              w_shift_nxt = r_last;
              w_idx_nxt   = IDX_TOP;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_shift_nxt     = r_hold;
      w_hold_full_nxt = 1'b0;
      w_idx_nxt       = IDX_TOP;
      w_state_nxt     = S_SHIFT;
    end
  end

  // Outputs decode registered state only.
  assign din_ready = !r_hold_full;
  assign x_valid   = (r_state == S_SHIFT);
  assign x         = (r_state == S_SHIFT) ? r_shift[WIDTH-1] : IDLE_LVL;
  assign bit_stb   = w_tick;
  assign word_done = w_word_done;
  assign bit_idx   = r_idx;

endmodule : seq_bitgen

// File: tb/tb_seq_bitgen.sv
// tb_seq_bitgen: directed bench for seq_bitgen. Instance u_dut uses DIV=1,
// u_dut4 uses DIV=4; both share clock and reset. Cycle c denotes the period
// following rising edge c; outputs are sampled 1ns after the edge.
module tb_seq_bitgen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din,  din4;
  logic       din_valid, din_valid4;
  logic       din_ready, din_ready4;
  logic       x, x4, x_valid, x_valid4;
  logic       bit_stb, bit_stb4, word_done, word_done4;
  logic [2:0] bit_idx, bit_idx4;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seq_bitgen #(.WIDTH(8), .DIV(1), .IDLE_LVL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .bit_stb(bit_stb),
    .word_done(word_done), .bit_idx(bit_idx)
  );

  seq_bitgen #(.WIDTH(8), .DIV(4), .IDLE_LVL(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid4),
    .din_ready(din_ready4), .x(x4), .x_valid(x_valid4), .bit_stb(bit_stb4),
    .word_done(word_done4), .bit_idx(bit_idx4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(x), 32'(1'b0));
    chk({tag, "_xv"}, 32'(x_valid), 32'(1'b0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0]  w8;
    logic [15:0] s16;
    logic [23:0] s24;
    logic [7:0]  words [3];
    int          k;
    logic        acc;

    rst = 1'b0; din = '0; din_valid = 1'b0; din4 = '0; din_valid4 = 1'b0;
    do_reset();

    // Reset state.
    chk("rst_x", 32'(x), 32'(1'b0));
    chk("rst_xv", 32'(x_valid), 32'(1'b0));
    chk("rst_stb", 32'(bit_stb), 32'(1'b0));
    chk("rst_wd", 32'(word_done), 32'(1'b0));
    chk("rst_rdy", 32'(din_ready), 32'(1'b1));
    chk("rst_idx", 32'(bit_idx), 32'(3'd7));
    chk("rst_rdy4", 32'(din_ready4), 32'(1'b1));

`ifndef SEQ_BITGEN_REPEAT_EN
    // Single word 0xB4: bits on cycles 2..9, idle at cycle 10.
    w8 = 8'hB4;
    din = w8; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("sw_c1_xv", 32'(x_valid), 32'(1'b0));
    chk("sw_c1_rdy", 32'(din_ready), 32'(1'b0));
    step();
    for (int i = 0; i < 8; i++) begin
      chk("sw_x", 32'(x), 32'(w8[3'(7 - i)]));
      chk("sw_xv", 32'(x_valid), 32'(1'b1));
      chk("sw_idx", 32'(bit_idx), 32'(7 - i));
      chk("sw_stb", 32'(bit_stb), 32'(1'b1));
      chk("sw_wd", 32'(word_done), 32'(i == 7));
      step();
    end
    chk_idle("sw_end");
    chk("sw_end_rdy", 32'(din_ready), 32'(1'b1));
    step();

    // Back-to-back 0xB4 then 0x0F: 16 contiguous bits.
    s16 = 16'hB40F;
    din = 8'hB4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("b2b_x", 32'(x), 32'(s16[4'(15 - i)]));
      chk("b2b_xv", 32'(x_valid), 32'(1'b1));
      chk("b2b_wd", 32'(word_done), 32'((i == 7) || (i == 15)));
      if (i == 0) chk("b2b_rdy0", 32'(din_ready), 32'(1'b1));
      if (i == 1) chk("b2b_rdy1", 32'(din_ready), 32'(1'b0));
      if (i == 0) begin din = 8'h0F; din_valid = 1'b1; end
      if (i == 1) din_valid = 1'b0;
      step();
    end
    chk_idle("b2b_end");
    step();

    // Backpressure: valid held with three words.
    words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h96;
    s24 = 24'hC35A96;
    k = 0;
    din = words[0]; din_valid = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      chk("bp_rdy", 32'(din_ready), 32'((c == 0) || (c == 2) || (c == 10) || (c >= 18)));
      if (c >= 2 && c <= 25) begin
        chk("bp_x", 32'(x), 32'(s24[5'(25 - c)]));
        chk("bp_xv", 32'(x_valid), 32'(1'b1));
        chk("bp_wd", 32'(word_done), 32'((c == 9) || (c == 17) || (c == 25)));
      end else begin
        chk_idle("bp_idle");
      end
      acc = din_valid && din_ready;
      step();
      if (acc) k++;
      if (k < 3) begin
        din = words[k]; din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
    end
    chk("bp_count", 32'(k), 32'(3));

    // Divider DIV=4 with 0x81.
    din4 = 8'h81; din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c >= 2 && c <= 33) begin
        chk("div_x", 32'(x4), 32'((c <= 5) || (c >= 30)));
        chk("div_xv", 32'(x_valid4), 32'(1'b1));
        chk("div_idx", 32'(bit_idx4), 32'(7 - (c - 2) / 4));
        chk("div_stb", 32'(bit_stb4), 32'(((c - 2) % 4) == 3));
        chk("div_wd", 32'(word_done4), 32'(c == 33));
      end else begin
        chk("div_idle_xv", 32'(x_valid4), 32'(1'b0));
        chk("div_idle_x", 32'(x4), 32'(1'b0));
      end
      step();
    end

    // Reset mid-word at bit 3 of 0xFF with 0x33 held.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    din = 8'h33; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step(); step();
    chk("rm_idx3", 32'(bit_idx), 32'(3'd3));
    chk("rm_x", 32'(x), 32'(1'b1));
    chk("rm_held", 32'(din_ready), 32'(1'b0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_idle("rm_after");
    chk("rm_rdy", 32'(din_ready), 32'(1'b1));
    chk("rm_idx", 32'(bit_idx), 32'(3'd7));
    chk("rm_wd", 32'(word_done), 32'(1'b0));
    for (int c = 0; c < 12; c++) begin
      chk("rm_quiet_xv", 32'(x_valid), 32'(1'b0));
      step();
    end
`else
    // Repeat: 0xB4 loops until 0x55 arrives mid-word, then 0x55 loops.
    s24 = 24'hB45555;
    din = 8'hB4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    for (int i = 0; i < 24; i++) begin
      chk("rep_x", 32'(x), 32'(s24[5'(23 - i)]));
      chk("rep_xv", 32'(x_valid), 32'(1'b1));
      chk("rep_wd", 32'(word_done), 32'((i % 8) == 7));
      if (i == 3) begin din = 8'h55; din_valid = 1'b1; end
      if (i == 4) din_valid = 1'b0;
      step();
    end
    w8 = 8'hB4;
    do_reset();
    din = w8; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    for (int i = 0; i < 24; i++) begin
      chk("rep2_x", 32'(x), 32'(w8[3'(7 - (i % 8))]));
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_seq_bitgen
